// File: rtl/math_word_count_div.sv
// math_word_count_div
//   Run-time divider for transfer sizing: quotient, remainder and ceiling
//   word count of size / word_size.
//   Iterative radix-2 restoring division, one quotient bit per clock, MSB first.
//   Valid/ready handshakes on the request and result sides.
//   A zero divisor skips the iteration and reports out_div_zero directly.
//   Optional feature macro: MATH_WORD_COUNT_CLOG2_EN adds out_clog2 = clog2(size).
module math_word_count_div #(
  parameter int WIDTH   = 32,
  parameter int CLOG2_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_size,
  input  logic [WIDTH-1:0]   in_word_size,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_quot,
  output logic [WIDTH-1:0]   out_rem,
  output logic [WIDTH-1:0]   out_word_count,
  output logic               out_div_zero
`ifdef MATH_WORD_COUNT_CLOG2_EN
  ,
  output logic [CLOG2_W-1:0] out_clog2
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  // dvd_q starts as the dividend and fills with quotient bits from the bottom
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  // Partial remainder after subtraction is always < divisor, so WIDTH bits hold it;
  // the shifted trial value needs the extra bit.
  logic [WIDTH-1:0]   prem_q, prem_d;
  logic [CLOG2_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   wc_q, wc_d;
  logic               dz_q, dz_d;

  logic [WIDTH:0]     trial;
  logic               fits;
  logic [WIDTH-1:0]   step_quot;
  logic [WIDTH-1:0]   step_rem;

`ifdef MATH_WORD_COUNT_CLOG2_EN
  logic [WIDTH-1:0]   size_q, size_d;
  logic [CLOG2_W-1:0] clog2_q, clog2_d;

  // Number of bits needed to represent v-1; 0 and 1 both map to 0
  function automatic logic [CLOG2_W-1:0] clog2_of(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0]   m;
    logic [CLOG2_W-1:0] r;
    m = (v == '0) ? '0 : v - 1'b1;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) r = CLOG2_W'(i + 1);
    end
    return r;
  endfunction
`endif

  // Next-state, datapath step and handshake outputs
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    wc_d      = wc_q;
    dz_d      = dz_q;
`ifdef MATH_WORD_COUNT_CLOG2_EN
    size_d    = size_q;
    clog2_d   = clog2_q;
`endif
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);

    // One restoring step: shift in next dividend bit, subtract if it fits
    trial     = {prem_q, dvd_q[WIDTH-1]};
    fits      = (trial >= {1'b0, dvs_q});
    step_quot = {dvd_q[WIDTH-2:0], fits};
    step_rem  = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvd_d  = in_size;
          dvs_d  = in_word_size;
          prem_d = '0;
          cnt_d  = CLOG2_W'(WIDTH - 1);
`ifdef MATH_WORD_COUNT_CLOG2_EN
          size_d = in_size;
`endif
          if (in_word_size == '0) begin
            quot_d  = '1;
            rem_d   = in_size;
            wc_d    = '0;
            dz_d    = 1'b1;
`ifdef MATH_WORD_COUNT_CLOG2_EN
            clog2_d = '0;
`endif
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        dvd_d  = step_quot;
        prem_d = step_rem;
        if (cnt_q == '0) begin
          // Final bit: results are taken straight from this step
          quot_d  = step_quot;
          rem_d   = step_rem;
          wc_d    = step_quot + WIDTH'(step_rem != '0);
          dz_d    = 1'b0;
`ifdef MATH_WORD_COUNT_CLOG2_EN
          clog2_d = clog2_of(size_q);
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      wc_q    <= '0;
      dz_q    <= 1'b0;
`ifdef MATH_WORD_COUNT_CLOG2_EN
      size_q  <= '0;
      clog2_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      wc_q    <= wc_d;
      dz_q    <= dz_d;
`ifdef MATH_WORD_COUNT_CLOG2_EN
      size_q  <= size_d;
      clog2_q <= clog2_d;
`endif
    end
  end

  assign out_quot       = quot_q;
  assign out_rem        = rem_q;
  assign out_word_count = wc_q;
  assign out_div_zero   = dz_q;
`ifdef MATH_WORD_COUNT_CLOG2_EN
  assign out_clog2      = clog2_q;
`endif

endmodule

// File: tb/tb_math_word_count_div.sv
// Testbench for math_word_count_div (WIDTH=8): directed boundary cases,
// output hold/backpressure, mid-operation reset, then randomized requests
// checked against an arithmetic reference model.
module tb_math_word_count_div;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_size;
  logic [W-1:0]  in_word_size;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_quot;
  logic [W-1:0]  out_rem;
  logic [W-1:0]  out_word_count;
  logic          out_div_zero;
`ifdef MATH_WORD_COUNT_CLOG2_EN
  logic [CW-1:0] out_clog2;
`endif

  int n_vec;
  int n_err;

  math_word_count_div #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_size        (in_size),
    .in_word_size   (in_word_size),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_quot       (out_quot),
    .out_rem        (out_rem),
    .out_word_count (out_word_count),
    .out_div_zero   (out_div_zero)
`ifdef MATH_WORD_COUNT_CLOG2_EN
    ,
    .out_clog2      (out_clog2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the request
  function automatic void model(input int sz, input int ws,
                                output int q, output int r, output int wc,
                                output int dz, output int cl);
    cl = 0;
    if (ws == 0) begin
      q = 255; r = sz; wc = 0; dz = 1;
    end else begin
      q  = sz / ws;
      r  = sz % ws;
      wc = (sz + ws - 1) / ws;
      dz = 0;
      while ((1 << cl) < sz) cl++;
    end
  endfunction

  // One full request: accept, latency, results, optional backpressure, release
  task automatic run_req(input logic [W-1:0] sz, input logic [W-1:0] ws, input int hold);
    int q, r, wc, dz, cl, lat;
    logic [W-1:0] sq, sr, sw;
    logic         sd;
    model(int'(sz), int'(ws), q, r, wc, dz, cl);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_size = sz; in_word_size = ws;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_size = W'($urandom); in_word_size = W'($urandom);
    check("accepted_in_ready", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (ws == 0) ? 1 : W + 1);
    check("quot", out_quot, q);
    check("rem", out_rem, r);
    check("word_count", out_word_count, wc);
    check("div_zero", out_div_zero, dz);
`ifdef MATH_WORD_COUNT_CLOG2_EN
    check("clog2", out_clog2, cl);
`endif
    $display("req size=%0d ws=%0d -> quot=%0d rem=%0d wc=%0d dz=%0d lat=%0d hold=%0d",
             sz, ws, out_quot, out_rem, out_word_count, out_div_zero, lat, hold);
    sq = out_quot; sr = out_rem; sw = out_word_count; sd = out_div_zero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_size = W'($urandom); in_word_size = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quot", out_quot, sq);
      check("hold_rem", out_rem, sr);
      check("hold_wc", out_word_count, sw);
      check("hold_dz", out_div_zero, sd);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int sel;
    logic [W-1:0] rs, rw;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_size = '0; in_word_size = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quot", out_quot, 0);
    check("rst_rem", out_rem, 0);
    check("rst_wc", out_word_count, 0);
    check("rst_dz", out_div_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    run_req(8'd100, 8'd8, 0);
    run_req(8'd64, 8'd8, 0);
    run_req(8'd255, 8'd1, 0);
    run_req(8'd37, 8'd0, 0);
    run_req(8'd0, 8'd5, 0);
    run_req(8'd3, 8'd200, 0);
    run_req(8'd100, 8'd8, 20);

    // Reset in the middle of BUSY
    @(negedge clk);
    in_valid = 1'b1; in_size = 8'd100; in_word_size = 8'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_quot", out_quot, 0);
    check("midrst_rem", out_rem, 0);
    check("midrst_wc", out_word_count, 0);
    $display("reset pulsed mid-busy: out_valid=%0d in_ready=%0d quot=%0d", out_valid, in_ready, out_quot);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", out_valid, 0);
    end
    run_req(8'd9, 8'd4, 0);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      rs  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
      if (sel == 0)      rw = '0;
      else if (sel < 4)  rw = W'($urandom_range(1, 4));
      else               rw = W'($urandom);
      run_req(rs, rw, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
